bin2bcd_seq: RTL and testbench

Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method, with a start/busy/done handshake and a leading-zero blanking mask. It sits between the 16-bit multiplier result and the 24-bit display-word mux, so the product appears on the six-digit display as decimal rather than hex. One conversion takes WIDTH+1 cycles on a single clock.

---
 rtl/bcd_pkg.sv | 30 +++
 rtl/bcd_add3.sv | 12 +
 rtl/bin2bcd_seq.sv | 135 +++++++++++++
 tb/tb_bin2bcd_seq.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types, constants and the digit-count helper for the binary-to-BCD converter.
package bcd_pkg;

  // Two-state converter control: waiting for a request, or shifting.
  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  // A BCD digit of 5 or more overflows past 9 when doubled; adding 3 first
  // makes the carry land in the next digit.
  localparam logic [3:0] ADD3_THRESHOLD = 4'd5;
  localparam int         BCD_DIGIT_W    = 4;

  // Number of decimal digits needed to show the largest width-bit value.
  function automatic int digits_needed(input int width);
    logic [127:0] maxv;
    int           n;
    maxv = (128'd1 << width) - 128'd1;
    n    = 1;
    for (int i = 0; i < 40; i++) begin
      if (maxv >= 128'd10) begin
        maxv = maxv / 128'd10;
        n++;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// One double-dabble correction cell: a 4-bit digit of 5 or more gets 3 added.
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] adjusted
);

  // The result stays 4 bits wide; the largest valid input (9) becomes 12.
  assign adjusted = (digit >= ADD3_THRESHOLD) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per cycle,
// with a start/busy/done handshake and a leading-zero blanking mask.
//
// Handshake: start is sampled only while idle; the accepting edge captures bin.
// busy is high from the cycle after acceptance until the result is posted;
// done is a one-cycle pulse in the cycle bcd/blank carry the new result, and
// the converter is idle again in that same cycle, so start held high then is
// accepted immediately. start during a conversion is dropped, not queued.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [WIDTH-1:0]              bin,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic [DIGITS-1:0]             blank
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  // Too few digits would silently lose the top of the result.
  if (DIGITS < digits_needed(WIDTH)) begin : g_bad_digits
    $error("bin2bcd_seq: DIGITS too small for WIDTH");
  end

  state_t                 state;
  state_t                 state_next;
  logic                   load;
  logic                   step;
  logic                   finish;
  logic [WIDTH-1:0]       bin_q;
  logic [BCD_W-1:0]       work_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [BCD_W-1:0]       work_adj;
  logic [BCD_W+WIDTH-1:0] shifted;
  logic [BCD_W-1:0]       work_next;
  logic [WIDTH-1:0]       bin_next;
  logic [DIGITS-1:0]      blank_next;
  logic                   upper_zero;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .digit    (work_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .adjusted (work_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Corrected digits and the binary operand shift left together as one word.
  assign shifted   = {work_adj, bin_q} << 1;
  assign work_next = shifted[BCD_W+WIDTH-1:WIDTH];
  assign bin_next  = shifted[WIDTH-1:0];

  // Blank digit i when it and every digit above it are zero; digit 0 always shows.
  always_comb begin
    blank_next = '0;
    upper_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_zero    = upper_zero && (work_next[i*BCD_DIGIT_W +: BCD_DIGIT_W] == 4'd0);
      blank_next[i] = upper_zero;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state and control strobes; the last shift is the one taken with count 1.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = CONV;
        end
      end
      CONV: begin
        step = 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Working registers: load on accept, one shift-and-correct per CONV cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      work_q <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      bin_q  <= bin;
      work_q <= '0;
      cnt_q  <= CNT_W'(WIDTH);
    end else if (step) begin
      bin_q  <= bin_next;
      work_q <= work_next;
      cnt_q  <= cnt_q - CNT_W'(1);
    end
  end

  // Registered outputs; bcd/blank move only when the finished value is posted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      bcd   <= '0;
      blank <= {{(DIGITS-1){1'b1}}, 1'b0};
    end else begin
      done <= finish;
      if (load)        busy <= 1'b1;
      else if (finish) busy <= 1'b0;
      if (finish) begin
        bcd   <= work_next;
        blank <= blank_next;
      end
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: fixed vectors, handshake corner cases,
// back-to-back streaming and random values against a decimal-arithmetic model.
module tb_bin2bcd_seq;

  localparam int WIDTH  = 16;
  localparam int DIGITS = 5;
  localparam int BW     = 4 * DIGITS;
  localparam int RW     = BW + DIGITS;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [WIDTH-1:0]  bin = '0;
  logic              busy;
  logic              done;
  logic [BW-1:0]     bcd;
  logic [DIGITS-1:0] blank;

  int compared   = 0;
  int mismatched = 0;

  logic [RW-1:0] exp_q[$];

  typedef struct {
    logic [WIDTH-1:0]  value;
    logic [BW-1:0]     exp_bcd;
    logic [DIGITS-1:0] exp_blank;
  } vec_t;

  vec_t vecs[8];

  bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd),
    .blank (blank)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain decimal digit extraction, blanking from magnitude.
  function automatic logic [RW-1:0] ref_model(input int unsigned v);
    logic [BW-1:0]     b;
    logic [DIGITS-1:0] bl;
    int unsigned       rem;
    int unsigned       p10;
    rem = v;
    b   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      b[4*i +: 4] = 4'(rem % 10);
      rem = rem / 10;
    end
    bl  = '0;
    p10 = 1;
    for (int i = 1; i < DIGITS; i++) begin
      p10   = p10 * 10;
      bl[i] = (v < p10);
    end
    return {b, bl};
  endfunction

  // ---------------- driver ----------------
  // Called at a negedge with the DUT idle. Requests a conversion of v, and
  // optionally pulses start with pulse_bin on the pulse_at-th cycle of CONV.
  // Returns the result, busy cycle count, done position (0 = timed out) and
  // whether bcd moved before done.
  task automatic run_conv(input logic [WIDTH-1:0] v, input int pulse_at,
                          input logic [WIDTH-1:0] pulse_bin,
                          output logic [BW-1:0] r_bcd, output logic [DIGITS-1:0] r_blank,
                          output int busy_cycles, output int done_at, output bit changed);
    logic [BW-1:0] prev;
    prev        = bcd;
    busy_cycles = 0;
    done_at     = 0;
    changed     = 1'b0;
    r_bcd       = '0;
    r_blank     = '0;
    start = 1'b1;
    bin   = v;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    bin   = WIDTH'($urandom);
    for (int i = 1; i <= 40; i++) begin
      if (done) begin
        done_at = i;
        r_bcd   = bcd;
        r_blank = blank;
        start   = 1'b0;
        break;
      end
      if (busy) busy_cycles++;
      if (bcd !== prev) changed = 1'b1;
      if (i == pulse_at) begin
        start = 1'b1;
        bin   = pulse_bin;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  // ---------------- test ----------------
  initial begin
    logic [BW-1:0]     r_bcd;
    logic [DIGITS-1:0] r_blank;
    logic [RW-1:0]     e;
    logic [WIDTH-1:0]  v;
    int                bc;
    int                da;
    bit                ch;
    int                ndone;
    int                last_done;
    int                nvals;

    vecs[0] = '{16'd0,     20'h00000, 5'b11110};
    vecs[1] = '{16'd65535, 20'h65535, 5'b00000};
    vecs[2] = '{16'd1234,  20'h01234, 5'b10000};
    vecs[3] = '{16'd10,    20'h00010, 5'b11100};
    vecs[4] = '{16'd9,     20'h00009, 5'b11110};
    vecs[5] = '{16'd100,   20'h00100, 5'b11000};
    vecs[6] = '{16'd10000, 20'h10000, 5'b00000};
    vecs[7] = '{16'd59999, 20'h59999, 5'b00000};

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy",  32'(busy),  32'd0);
    check("reset_done",  32'(done),  32'd0);
    check("reset_bcd",   32'(bcd),   32'd0);
    check("reset_blank", 32'(blank), 32'b11110);
    rst_n = 1'b1;
    @(negedge clk);

    // Fixed vectors, with latency and output-stability checks
    for (int k = 0; k < 8; k++) begin
      run_conv(vecs[k].value, 0, '0, r_bcd, r_blank, bc, da, ch);
      check($sformatf("vec%0d_bcd", k),     32'(r_bcd),   32'(vecs[k].exp_bcd));
      check($sformatf("vec%0d_blank", k),   32'(r_blank), 32'(vecs[k].exp_blank));
      check($sformatf("vec%0d_busy", k),    32'(bc),      32'd16);
      check($sformatf("vec%0d_latency", k), 32'(da),      32'd17);
      check($sformatf("vec%0d_stable", k),  32'(ch),      32'd0);
      @(negedge clk);
      check($sformatf("vec%0d_done_1cyc", k), 32'(done), 32'd0);
    end

    // Start during CONV is ignored: only the first result, only one done
    run_conv(16'd9, 5, 16'd500, r_bcd, r_blank, bc, da, ch);
    check("ign_bcd",     32'(r_bcd), 32'h00009);
    check("ign_latency", 32'(da),    32'd17);
    ndone = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    check("ign_no_second", 32'(ndone), 32'd0);

    // Reset during CONV aborts without a done
    start = 1'b1;
    bin   = 16'd300;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("abort_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy",  32'(busy),  32'd0);
    check("abort_done",  32'(done),  32'd0);
    check("abort_bcd",   32'(bcd),   32'd0);
    check("abort_blank", 32'(blank), 32'b11110);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'd0);

    // Back-to-back with start held high, alternating 42 / 999
    exp_q.push_back(ref_model(42));
    start     = 1'b1;
    bin       = 16'd42;
    nvals     = 1;
    ndone     = 0;
    last_done = -1;
    for (int c = 0; c < 100 && ndone < 4; c++) begin
      @(negedge clk);
      if (done) begin
        e = exp_q.pop_front();
        check($sformatf("b2b%0d_bcd", ndone),   32'(bcd),   32'(e[RW-1:DIGITS]));
        check($sformatf("b2b%0d_blank", ndone), 32'(blank), 32'(e[DIGITS-1:0]));
        if (last_done >= 0) check($sformatf("b2b%0d_period", ndone), 32'(c - last_done), 32'd17);
        last_done = c;
        ndone++;
        if (ndone < 4) begin
          v = (nvals % 2 == 1) ? 16'd999 : 16'd42;
          exp_q.push_back(ref_model(int'(v)));
          bin = v;
          nvals++;
        end
      end
    end
    start = 1'b0;
    check("b2b_count", 32'(ndone), 32'd4);
    exp_q.delete();
    repeat (20) @(negedge clk);

    // Random values against the decimal model
    for (int k = 0; k < 40; k++) begin
      v = WIDTH'($urandom_range(0, 65535));
      if (k < 4) v = WIDTH'($urandom_range(0, 20));
      exp_q.push_back(ref_model(int'(v)));
      run_conv(v, 0, '0, r_bcd, r_blank, bc, da, ch);
      e = exp_q.pop_front();
      if (da == 0) begin
        check($sformatf("rand%0d_timeout", k), 32'd0, 32'd1);
      end else begin
        check($sformatf("rand%0d_bcd_%0d", k, v), 32'(r_bcd),   32'(e[RW-1:DIGITS]));
        check($sformatf("rand%0d_blank_%0d", k, v), 32'(r_blank), 32'(e[DIGITS-1:0]));
      end
    end

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
